// File: rtl/dbg_abs_gpr_access_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dbg_abs_gpr_access_if                                          |
// | Purpose : Bundles the DMI-side command/data0 signals and the core        |
// |           register-file debug port of the abstract GPR access engine.    |
// |           o_regno_next exists only when DBG_POSTINC_EN is defined.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface dbg_abs_gpr_access_if #(
  parameter int XLEN_DBG = 32
);
  // DMI command side
  logic                i_cmd_valid;
  logic [15:0]         i_cmd_regno;
  logic                i_cmd_write;
  logic                i_cmd_transfer;
  logic                i_cmd_postinc;
  logic                i_data0_we;
  logic [XLEN_DBG-1:0] i_data0_wdata;
  logic [2:0]          i_cmderr_clr;
  logic [XLEN_DBG-1:0] o_data0;
  logic                o_busy;
  logic [2:0]          o_cmderr;
  // Core side
  logic                i_halted;
  logic [4:0]          o_dbg_gpr_addr;
  logic [XLEN_DBG-1:0] o_dbg_gpr_in;
  logic                o_dbg_gpr_rd;
  logic                o_dbg_gpr_wr;
  logic [XLEN_DBG-1:0] i_dbg_gpr_out;
`ifdef DBG_POSTINC_EN
  logic [15:0]         o_regno_next;
`endif

  modport slave (
    input  i_cmd_valid, i_cmd_regno, i_cmd_write, i_cmd_transfer, i_cmd_postinc,
    input  i_data0_we, i_data0_wdata, i_cmderr_clr, i_halted, i_dbg_gpr_out,
    output o_data0, o_busy, o_cmderr, o_dbg_gpr_addr, o_dbg_gpr_in,
    output o_dbg_gpr_rd, o_dbg_gpr_wr
`ifdef DBG_POSTINC_EN
    , output o_regno_next
`endif
  );

  modport master (
    output i_cmd_valid, i_cmd_regno, i_cmd_write, i_cmd_transfer, i_cmd_postinc,
    output i_data0_we, i_data0_wdata, i_cmderr_clr, i_halted, i_dbg_gpr_out,
    input  o_data0, o_busy, o_cmderr, o_dbg_gpr_addr, o_dbg_gpr_in,
    input  o_dbg_gpr_rd, o_dbg_gpr_wr
`ifdef DBG_POSTINC_EN
    , input o_regno_next
`endif
  );
endinterface
`default_nettype wire

// File: rtl/dbg_abs_gpr_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dbg_abs_gpr_access                                             |
// | Purpose : Abstract-command engine for Access Register commands on GPRs.  |
// |           Owns data0, busy and sticky cmderr; drives the register-file   |
// |           debug port with single-cycle read/write strobes.               |
// |           Optional: DBG_POSTINC_EN enables aarpostincrement and the      |
// |           o_regno_next output.                                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dbg_abs_gpr_access #(
  parameter logic [15:0] REGNO_BASE = 16'h1000,
  parameter int          XLEN_DBG   = 32
) (
  input  wire logic               clk,
  input  wire logic               rstn,
  dbg_abs_gpr_access_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] C_ERR_NONE  = 3'd0;
  localparam logic [2:0] C_ERR_BUSY  = 3'd1;
  localparam logic [2:0] C_ERR_UNSUP = 3'd2;
  localparam logic [2:0] C_ERR_HALT  = 3'd4;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN_DBG-1:0] r_data0;
  logic [2:0]          r_cmderr;
  logic [2:0]          w_cmderr_nxt;
  logic [2:0]          w_err;
  logic [4:0]          r_addr;
  logic [15:0]         r_regno;
  logic                r_write;
  logic                r_transfer;
  logic [15:0]         w_regno_off;
  logic                w_in_range;
  logic                w_accept;
  logic                w_go_access;
  logic                w_rd;
  logic                w_wr;
  logic                w_busy_viol;
`ifdef DBG_POSTINC_EN
  logic                r_postinc;
  logic                r_ok;
`endif

  // Offset from x0's regno; subtraction wraps so regnos below the base land far out of range
  assign w_regno_off = r_regno - REGNO_BASE;
  assign w_in_range  = (w_regno_off < 16'd32);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, strobes and the error to record this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_err       = C_ERR_NONE;
    w_accept    = 1'b0;
    w_go_access = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_cmd_valid && (r_cmderr == C_ERR_NONE)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!r_transfer) begin
          w_state_nxt = S_DONE;
        end else if (!w_in_range) begin
          w_err       = C_ERR_UNSUP;
          w_state_nxt = S_DONE;
        end else if (!bus.i_halted) begin
          w_err       = C_ERR_HALT;
          w_state_nxt = S_DONE;
        end else begin
          w_go_access = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Core may leave halt between CHECK and ACCESS: suppress the strobe then
        if (bus.i_halted) begin
          w_rd = ~r_write;
          w_wr = r_write;
        end else begin
          w_err = C_ERR_HALT;
        end
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // DMI traffic while busy is a busy error; a command error wins over it and over the clear
    w_busy_viol  = (r_state != S_IDLE) && (bus.i_cmd_valid || bus.i_data0_we);
    w_cmderr_nxt = r_cmderr & ~bus.i_cmderr_clr;
    if (w_err != C_ERR_NONE)
      w_cmderr_nxt = w_err;
    else if (w_busy_viol && (r_cmderr == C_ERR_NONE))
      w_cmderr_nxt = C_ERR_BUSY;
  end

  // Command latch, data0, cmderr and register-file address
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data0    <= '0;
      r_cmderr   <= C_ERR_NONE;
      r_addr     <= '0;
      r_regno    <= '0;
      r_write    <= 1'b0;
      r_transfer <= 1'b0;
`ifdef DBG_POSTINC_EN
      r_postinc  <= 1'b0;
      r_ok       <= 1'b0;
`endif
    end else begin
      r_cmderr <= w_cmderr_nxt;
      if (w_accept) begin
        r_regno    <= bus.i_cmd_regno;
        r_write    <= bus.i_cmd_write;
        r_transfer <= bus.i_cmd_transfer;
`ifdef DBG_POSTINC_EN
        r_postinc  <= bus.i_cmd_postinc;
        r_ok       <= 1'b0;
`endif
      end
      // DMI owns data0 only while idle; a read access overwrites it
      if ((r_state == S_IDLE) && bus.i_data0_we)
        r_data0 <= bus.i_data0_wdata;
      else if (w_rd)
        r_data0 <= bus.i_dbg_gpr_out;
      if (w_go_access)
        r_addr <= r_regno[4:0];
`ifdef DBG_POSTINC_EN
      if (w_rd || w_wr)
        r_ok <= 1'b1;
      if ((r_state == S_DONE) && r_ok && r_postinc)
        r_regno <= r_regno + 16'd1;
`endif
    end
  end

  assign bus.o_data0        = r_data0;
  assign bus.o_busy         = (r_state != S_IDLE);
  assign bus.o_cmderr       = r_cmderr;
  assign bus.o_dbg_gpr_addr = r_addr;
  assign bus.o_dbg_gpr_in   = r_data0;
  assign bus.o_dbg_gpr_rd   = w_rd;
  assign bus.o_dbg_gpr_wr   = w_wr;
`ifdef DBG_POSTINC_EN
  assign bus.o_regno_next   = r_regno;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbg_abs_gpr_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dbg_abs_gpr_access                                          |
// | Purpose : Self-checking bench: directed vector table, hand sequences for |
// |           multi-cycle corners, then randomized traffic against a model.  |
// |           Honours DBG_POSTINC_EN when defined.                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dbg_abs_gpr_access;
  localparam logic [15:0] BASE = 16'h1000;
`ifdef DBG_POSTINC_EN
  localparam bit PI_EN = 1'b1;
`else
  localparam bit PI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dbg_abs_gpr_access_if #(.XLEN_DBG(32)) bus ();
  dbg_abs_gpr_access #(.REGNO_BASE(BASE), .XLEN_DBG(32)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Register file model: x0 hardwired to zero, writes land at the clock edge
  logic [31:0] regs [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.o_dbg_gpr_wr) begin
      if (bus.o_dbg_gpr_addr != 5'd0) regs[bus.o_dbg_gpr_addr] <= bus.o_dbg_gpr_in;
    end else if (pre_we && pre_idx != 5'd0) begin
      regs[pre_idx] <= pre_val;
    end
  end
  assign bus.i_dbg_gpr_out = regs[bus.o_dbg_gpr_addr];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_cmd_valid    = 1'b0;
    bus.i_cmd_regno    = '0;
    bus.i_cmd_write    = 1'b0;
    bus.i_cmd_transfer = 1'b0;
    bus.i_cmd_postinc  = 1'b0;
    bus.i_data0_we     = 1'b0;
    bus.i_data0_wdata  = '0;
    bus.i_cmderr_clr   = '0;
    bus.i_halted       = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic clear_err();
    bus.i_cmderr_clr = 3'b111;
    @(negedge clk);
    bus.i_cmderr_clr = 3'b000;
  endtask

  task automatic set_data0(input logic [31:0] v);
    bus.i_data0_we = 1'b1; bus.i_data0_wdata = v;
    @(negedge clk);
    bus.i_data0_we = 1'b0;
  endtask

  // Issue one command and observe it until busy drops (bounded)
  task automatic run_cmd(input logic [15:0] regno, input logic wr, input logic tr, input logic pi,
                         input logic extra_valid, output int busy_n, output int rd_n,
                         output int wr_n, output logic [4:0] s_addr, output logic [31:0] s_in);
    busy_n = 0; rd_n = 0; wr_n = 0; s_addr = '0; s_in = '0;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_regno = regno; bus.i_cmd_write = wr;
    bus.i_cmd_transfer = tr; bus.i_cmd_postinc = pi;
    @(negedge clk);
    bus.i_cmd_valid = extra_valid;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!bus.o_busy) break;
      busy_n++;
      if (bus.o_dbg_gpr_rd) begin rd_n++; s_addr = bus.o_dbg_gpr_addr; end
      if (bus.o_dbg_gpr_wr) begin wr_n++; s_addr = bus.o_dbg_gpr_addr; s_in = bus.o_dbg_gpr_in; end
      @(negedge clk);
      bus.i_cmd_valid = 1'b0;
    end
    bus.i_cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] regno;
    logic        wr;
    logic        tr;
    logic        halted;
    logic [31:0] d0;
    logic [31:0] rv;
    logic [2:0]  e_err;
    logic [31:0] e_d0;
    int          e_rd;
    int          e_wr;
    int          e_busy;
    logic [4:0]  e_addr;
  } vec_t;

  vec_t vt [10];

  // Reference model state: cycles since acceptance (0 = idle)
  int          m_age;
  logic [15:0] m_regno;
  logic        m_write, m_transfer, m_postinc, m_ok;
  logic [31:0] m_data0;
  logic [2:0]  m_err;
  logic [4:0]  m_addr;

  task automatic model_step();
    logic [2:0]  new_err;
    logic [2:0]  e;
    logic        viol;
    int          off;
    new_err = 3'd0;
    off  = int'(m_regno) - int'(BASE);
    viol = (m_age != 0) && (bus.i_cmd_valid || bus.i_data0_we);
    case (m_age)
      0: begin
        if (bus.i_data0_we) m_data0 = bus.i_data0_wdata;
        if (bus.i_cmd_valid && m_err == 3'd0) begin
          m_regno = bus.i_cmd_regno; m_write = bus.i_cmd_write;
          m_transfer = bus.i_cmd_transfer; m_postinc = bus.i_cmd_postinc;
          m_ok = 1'b0; m_age = 1;
        end
      end
      1: begin
        if (!m_transfer) m_age = 3;
        else if (off < 0 || off > 31) begin new_err = 3'd2; m_age = 3; end
        else if (!bus.i_halted) begin new_err = 3'd4; m_age = 3; end
        else begin m_addr = m_regno[4:0]; m_age = 2; end
      end
      2: begin
        if (bus.i_halted) begin
          if (!m_write) m_data0 = regs[m_addr];
          m_ok = 1'b1;
        end else new_err = 3'd4;
        m_age = 3;
      end
      default: begin
        if (PI_EN && m_postinc && m_ok) m_regno = m_regno + 16'd1;
        m_age = 0;
      end
    endcase
    e = m_err & ~bus.i_cmderr_clr;
    if (new_err != 3'd0) e = new_err;
    else if (viol && m_err == 3'd0) e = 3'd1;
    m_err = e;
  endtask

  initial begin
    int          bn, rn, wn;
    logic [4:0]  sa;
    logic [31:0] si;
    logic        exp_rd, exp_wr;
    int          sel;

    // ---------------- reset ----------------
    do_reset();
    #1;
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_cmderr", bus.o_cmderr, 0);
    chk("reset_data0", bus.o_data0, 0);
    chk("reset_rd", bus.o_dbg_gpr_rd, 0);
    chk("reset_wr", bus.o_dbg_gpr_wr, 0);
    chk("reset_addr", bus.o_dbg_gpr_addr, 0);
    @(negedge clk);

    // ---------------- vector table ----------------
    vt[0] = '{16'h1005, 1'b0, 1'b1, 1'b1, 32'h0,        32'hDEADBEEF, 3'd0, 32'hDEADBEEF, 1, 0, 3, 5'd5};
    vt[1] = '{16'h101F, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'h0,        3'd0, 32'h12345678, 0, 1, 3, 5'd31};
    vt[2] = '{16'h1000, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h11111111, 3'd0, 32'h0,        1, 0, 3, 5'd0};
    vt[3] = '{16'h1000, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0,        3'd0, 32'hCAFEF00D, 0, 1, 3, 5'd0};
    vt[4] = '{16'h101F, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0BADC0DE, 3'd0, 32'h0BADC0DE, 1, 0, 3, 5'd31};
    vt[5] = '{16'h1001, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 32'h77777777, 3'd4, 32'h55AA55AA, 0, 0, 2, 5'd0};
    vt[6] = '{16'h0300, 1'b0, 1'b1, 1'b1, 32'h1,        32'h2,        3'd2, 32'h1,        0, 0, 2, 5'd0};
    vt[7] = '{16'h1020, 1'b1, 1'b1, 1'b1, 32'h3,        32'h0,        3'd2, 32'h3,        0, 0, 2, 5'd0};
    vt[8] = '{16'h0FFF, 1'b0, 1'b1, 1'b1, 32'h4,        32'h0,        3'd2, 32'h4,        0, 0, 2, 5'd0};
    vt[9] = '{16'h1005, 1'b0, 1'b0, 1'b1, 32'h9,        32'h1234,     3'd0, 32'h9,        0, 0, 2, 5'd0};

    for (int v = 0; v < 10; v++) begin
      clear_err();
      set_data0(vt[v].d0);
      preload(vt[v].regno[4:0], vt[v].rv);
      bus.i_halted = vt[v].halted;
      run_cmd(vt[v].regno, vt[v].wr, vt[v].tr, 1'b0, 1'b0, bn, rn, wn, sa, si);
      bus.i_halted = 1'b1;
      #1;
      chk($sformatf("v%0d_cmderr", v), bus.o_cmderr, vt[v].e_err);
      chk($sformatf("v%0d_data0", v), bus.o_data0, vt[v].e_d0);
      chk($sformatf("v%0d_rd_pulses", v), rn, vt[v].e_rd);
      chk($sformatf("v%0d_wr_pulses", v), wn, vt[v].e_wr);
      chk($sformatf("v%0d_busy_cycles", v), bn, vt[v].e_busy);
      if (vt[v].e_rd + vt[v].e_wr != 0) chk($sformatf("v%0d_addr", v), sa, vt[v].e_addr);
      if (vt[v].e_wr != 0) begin
        chk($sformatf("v%0d_gpr_in", v), si, vt[v].d0);
        chk($sformatf("v%0d_regfile", v), regs[vt[v].e_addr], (vt[v].e_addr == 5'd0) ? 32'h0 : vt[v].d0);
      end
      @(negedge clk);
    end

    // ---------------- not halted: later commands ignored until cleared ----------------
    clear_err();
    bus.i_halted = 1'b0;
    run_cmd(16'h1001, 1'b0, 1'b1, 1'b0, 1'b0, bn, rn, wn, sa, si);
    bus.i_halted = 1'b1;
    #1 chk("nothalt_cmderr", bus.o_cmderr, 4);
    @(negedge clk);
    run_cmd(16'h1005, 1'b0, 1'b1, 1'b0, 1'b0, bn, rn, wn, sa, si);
    chk("ignored_busy", bn, 0);
    chk("ignored_rd", rn, 0);
    chk("ignored_cmderr", bus.o_cmderr, 4);
    @(negedge clk);
    bus.i_cmderr_clr = 3'b011;
    @(negedge clk);
    bus.i_cmderr_clr = 3'b000;
    #1 chk("partial_clear", bus.o_cmderr, 4);
    @(negedge clk);
    clear_err();
    #1 chk("cleared_cmderr", bus.o_cmderr, 0);
    @(negedge clk);

    // ---------------- busy error: second cmd_valid right after acceptance ----------------
    preload(5'd5, 32'hDEADBEEF);
    run_cmd(16'h1005, 1'b0, 1'b1, 1'b0, 1'b1, bn, rn, wn, sa, si);
    chk("busyerr_cmderr", bus.o_cmderr, 1);
    chk("busyerr_busy", bn, 3);
    chk("busyerr_rd", rn, 1);
    chk("busyerr_data0", bus.o_data0, 32'hDEADBEEF);
    @(negedge clk);

    // ---------------- data0_we while busy, same cycle as a full clear ----------------
    clear_err();
    set_data0(32'h0);
    preload(5'd6, 32'h00006666);
    bus.i_cmd_valid = 1'b1; bus.i_cmd_regno = 16'h1006; bus.i_cmd_write = 1'b0;
    bus.i_cmd_transfer = 1'b1; bus.i_cmd_postinc = 1'b0;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_data0_we = 1'b1; bus.i_data0_wdata = 32'hFFFFFFFF; bus.i_cmderr_clr = 3'b111;
    @(negedge clk);
    bus.i_data0_we = 1'b0; bus.i_cmderr_clr = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    chk("we_busy_cmderr", bus.o_cmderr, 1);
    chk("we_busy_data0", bus.o_data0, 32'h00006666);
    chk("we_busy_idle", bus.o_busy, 0);
    @(negedge clk);

    // ---------------- reset mid-command ----------------
    clear_err();
    bus.i_cmd_valid = 1'b1; bus.i_cmd_regno = 16'h1005; bus.i_cmd_write = 1'b1; bus.i_cmd_transfer = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_wr", bus.o_dbg_gpr_wr, 0);
    chk("midrst_data0", bus.o_data0, 0);
    rstn = 1'b1;
    @(negedge clk);
    #1 chk("midrst_stays_idle", bus.o_busy, 0);
    @(negedge clk);

`ifdef DBG_POSTINC_EN
    // ---------------- post-increment ----------------
    preload(5'd31, 32'h31313131);
    run_cmd(16'h101F, 1'b0, 1'b1, 1'b1, 1'b0, bn, rn, wn, sa, si);
    chk("pi_rd", rn, 1);
    chk("pi_addr", sa, 31);
    chk("pi_regno_next", bus.o_regno_next, 16'h1020);
    @(negedge clk);
    run_cmd(bus.o_regno_next, 1'b0, 1'b1, 1'b1, 1'b0, bn, rn, wn, sa, si);
    chk("pi_reissue_cmderr", bus.o_cmderr, 2);
    chk("pi_reissue_regno_next", bus.o_regno_next, 16'h1020);
    @(negedge clk);
`endif

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    m_age = 0; m_regno = '0; m_write = 1'b0; m_transfer = 1'b0; m_postinc = 1'b0;
    m_ok = 1'b0; m_data0 = '0; m_err = '0; m_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      bus.i_cmd_valid    = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      bus.i_cmd_regno = 16'($urandom_range(0, 16'hFFFF));
      else if (sel == 1) bus.i_cmd_regno = ($urandom_range(0, 1) == 0) ? BASE + 16'd32 : BASE - 16'd1;
      else               bus.i_cmd_regno = BASE + 16'($urandom_range(0, 31));
      bus.i_cmd_write    = 1'($urandom_range(0, 1));
      bus.i_cmd_transfer = ($urandom_range(0, 7) != 0);
      bus.i_cmd_postinc  = 1'($urandom_range(0, 1));
      bus.i_data0_we     = ($urandom_range(0, 7) == 0);
      bus.i_data0_wdata  = $urandom;
      bus.i_cmderr_clr   = ($urandom_range(0, 5) == 0) ? 3'b111 : 3'($urandom_range(0, 7) == 0 ? $urandom_range(0, 7) : 0);
      bus.i_halted       = ($urandom_range(0, 9) != 0);
      #1;
      exp_rd = (m_age == 2) && !m_write && bus.i_halted;
      exp_wr = (m_age == 2) && m_write && bus.i_halted;
      chk("rnd_busy", bus.o_busy, (m_age != 0));
      chk("rnd_rd", bus.o_dbg_gpr_rd, exp_rd);
      chk("rnd_wr", bus.o_dbg_gpr_wr, exp_wr);
      chk("rnd_cmderr", bus.o_cmderr, m_err);
      chk("rnd_data0", bus.o_data0, m_data0);
      if (exp_rd || exp_wr) chk("rnd_addr", bus.o_dbg_gpr_addr, m_addr);
      if (exp_wr) chk("rnd_gpr_in", bus.o_dbg_gpr_in, m_data0);
`ifdef DBG_POSTINC_EN
      chk("rnd_regno_next", bus.o_regno_next, m_regno);
`endif
      model_step();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 1000000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
